// File: rtl/ne_fp_norm_lzc_w16s4.sv
//==============================================================================
// Module   : ne_fp_norm_lzc_w16s4
// Brief    : Two-stage LZC + left-shift normaliser with exponent rebias.
//            Optional macro NE_NORM_UF_FLUSH_EN: flush mantissa to zero on
//            exponent underflow (default build keeps gradual underflow).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ne_fp_sfl_blk_w16s4 #(
  parameter int BW_DATA = 16,
  parameter int BW_SF   = 4,
  parameter bit SIGNED  = 1'b0
) (
  input  logic [BW_DATA-1:0] din,
  input  logic [BW_SF-1:0]   sf,
  output logic [BW_DATA-1:0] dout
);

  logic [BW_DATA-1:0] w_stg [BW_SF+1];

  assign w_stg[0] = din;

  // Log-depth barrel: stage i shifts by 2**i when sf[i] is set.
  for (genvar i = 0; i < BW_SF; i++) begin : g_stage
    assign w_stg[i+1] = sf[i] ? (w_stg[i] << (1 << i)) : w_stg[i];
  end

  if (SIGNED) begin : g_signed
    assign dout = {din[BW_DATA-1], w_stg[BW_SF][BW_DATA-2:0]};
  end else begin : g_unsigned
    assign dout = w_stg[BW_SF];
  end

endmodule

module ne_fp_norm_lzc_w16s4 #(
  parameter int BW_MANT = 16,
  parameter int BW_SF   = 4,
  parameter int BW_EXP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [BW_MANT-1:0] in_mant,
  input  logic [BW_EXP-1:0]  in_exp,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [BW_MANT-1:0] out_mant,
  output logic [BW_EXP-1:0]  out_exp,
  output logic               out_zero,
  output logic               out_uf
);

  logic               r_s1_vld;
  logic [BW_MANT-1:0] r_s1_mant;
  logic [BW_EXP-1:0]  r_s1_exp;
  logic [BW_SF-1:0]   r_s1_lzc;
  logic               r_s1_zero;

  logic               r_s2_vld;
  logic [BW_MANT-1:0] r_s2_mant;
  logic [BW_EXP-1:0]  r_s2_exp;
  logic               r_s2_zero;
  logic               r_s2_uf;

  logic               w_s1_adv;
  logic               w_s2_adv;
  logic [BW_SF-1:0]   w_lzc;
  logic [BW_EXP:0]    w_diff;
  logic [BW_SF-1:0]   w_sh;
  logic [BW_MANT-1:0] w_shifted;
  logic [BW_MANT-1:0] w_s2_mant;
  logic [BW_EXP-1:0]  w_s2_exp;
  logic               w_s2_uf;

  assign w_s2_adv = ~r_s2_vld | out_rdy;
  assign w_s1_adv = ~r_s1_vld | w_s2_adv;
  assign in_rdy   = w_s1_adv;

  // Highest set bit wins (last assignment); all-zero input leaves lzc at 0.
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < BW_MANT; i++) begin
      if (in_mant[i]) w_lzc = BW_SF'(BW_MANT - 1 - i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_mant <= '0;
      r_s1_exp  <= '0;
      r_s1_lzc  <= '0;
      r_s1_zero <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_vld <= in_vld;
      if (in_vld) begin
        r_s1_mant <= in_mant;
        r_s1_exp  <= in_exp;
        r_s1_lzc  <= w_lzc;
        r_s1_zero <= (in_mant == '0);
      end
    end
  end

  // Borrow out of the widened subtract flags underflow.
  assign w_diff = {1'b0, r_s1_exp} - {{(BW_EXP+1-BW_SF){1'b0}}, r_s1_lzc};

  // On underflow exp < lzc <= 15, so exp fits the shift field without loss.
  assign w_sh = (w_diff[BW_EXP] && !r_s1_zero) ? r_s1_exp[BW_SF-1:0] : r_s1_lzc;

  ne_fp_sfl_blk_w16s4 #(
    .BW_DATA (BW_MANT),
    .BW_SF   (BW_SF),
    .SIGNED  (1'b0)
  ) u_sfl (
    .din  (r_s1_mant),
    .sf   (w_sh),
    .dout (w_shifted)
  );

  always_comb begin
    w_s2_mant = w_shifted;
    w_s2_exp  = w_diff[BW_EXP-1:0];
    w_s2_uf   = 1'b0;
    if (r_s1_zero) begin
      w_s2_mant = '0;
      w_s2_exp  = '0;
    end else if (w_diff[BW_EXP]) begin
      w_s2_uf  = 1'b1;
      w_s2_exp = '0;
`ifdef NE_NORM_UF_FLUSH_EN
      w_s2_mant = '0;
`else
      w_s2_mant = w_shifted;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_mant <= '0;
      r_s2_exp  <= '0;
      r_s2_zero <= 1'b0;
      r_s2_uf   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_mant <= w_s2_mant;
        r_s2_exp  <= w_s2_exp;
        r_s2_zero <= r_s1_zero;
        r_s2_uf   <= w_s2_uf;
      end
    end
  end

  assign out_vld  = r_s2_vld;
  assign out_mant = r_s2_mant;
  assign out_exp  = r_s2_exp;
  assign out_zero = r_s2_zero;
  assign out_uf   = r_s2_uf;

endmodule

`default_nettype wire

// File: tb/tb_ne_fp_norm_lzc_w16s4.sv
//==============================================================================
// Module   : tb_ne_fp_norm_lzc_w16s4
// Brief    : Scoreboard bench for the two-stage mantissa normaliser.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ne_fp_norm_lzc_w16s4;

  typedef struct {
    logic [15:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        uf;
    int          acc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [15:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_uf;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  bit    lat_chk = 1'b1;
  bit    head_seen = 1'b0;
  bit    saw_stall;
  beat_t sb[$];
  beat_t mon_h;
  logic [15:0] bm[$];
  logic [7:0]  be[$];

  ne_fp_norm_lzc_w16s4 dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_mant  (in_mant),
    .in_exp   (in_exp),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_mant (out_mant),
    .out_exp  (out_exp),
    .out_zero (out_zero),
    .out_uf   (out_uf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: normalise by shifting until the MSB is set, counting steps.
  function automatic beat_t model(input logic [15:0] m, input logic [7:0] e, input int acc);
    beat_t r;
    logic [15:0] t;
    int n;
    r.acc = acc; r.zero = 1'b0; r.uf = 1'b0;
    if (m == 16'h0) begin
      r.mant = 16'h0; r.exp = 8'h0; r.zero = 1'b1;
      return r;
    end
    t = m; n = 0;
    while (!t[15]) begin t = t << 1; n++; end
    if (int'(e) >= n) begin
      r.mant = t; r.exp = 8'(int'(e) - n);
    end else begin
      r.uf = 1'b1; r.exp = 8'h0;
`ifdef NE_NORM_UF_FLUSH_EN
      r.mant = 16'h0;
`else
      r.mant = m << e;
`endif
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld) begin
        if (sb.size() == 0) begin
          check_val("spurious_out", 32'd1, 32'd0);
        end else begin
          mon_h = sb[0];
          check_val("out_mant", 32'(out_mant), 32'(mon_h.mant));
          check_val("out_exp",  32'(out_exp),  32'(mon_h.exp));
          check_val("out_zero", 32'(out_zero), 32'(mon_h.zero));
          check_val("out_uf",   32'(out_uf),   32'(mon_h.uf));
          if (lat_chk && !head_seen) check_val("latency", 32'(cyc - mon_h.acc), 32'd2);
          head_seen = 1'b1;
          if (out_rdy) begin
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (in_vld && in_rdy) sb.push_back(model(in_mant, in_exp, cyc));
    end
  end

  task automatic send(input logic [15:0] m, input logic [7:0] e);
    int n = 0;
    in_vld = 1'b1; in_mant = m; in_exp = e;
    @(negedge clk);
    while (!in_rdy && n < 50) begin n++; @(negedge clk); end
    if (!in_rdy) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check_val("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic single(input logic [15:0] m, input logic [7:0] e);
    send(m, e);
    in_vld = 1'b0;
    drain();
  endtask

  // mode 0: out_rdy low for cycles 3-6; mode 1: random valid/ready.
  task automatic run_stream(input int mode);
    int idx = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 400 && idx < bm.size(); c++) begin
      out_rdy = (mode == 0) ? !(c >= 3 && c <= 6) : ($urandom_range(0, 3) != 0);
      in_vld  = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      in_mant = bm[idx];
      in_exp  = be[idx];
      @(negedge clk);
      if (in_vld && !in_rdy) saw_stall = 1'b1;
      if (in_vld && in_rdy) idx++;
      @(posedge clk); #1;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    check_val("stream_sent", 32'(idx), 32'(bm.size()));
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_mant = '0; in_exp = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_vld",  32'(out_vld),  32'd0);
    check_val("rst_out_mant", 32'(out_mant), 32'd0);
    check_val("rst_out_exp",  32'(out_exp),  32'd0);
    check_val("rst_out_zero", 32'(out_zero), 32'd0);
    check_val("rst_out_uf",   32'(out_uf),   32'd0);
    check_val("rst_in_rdy",   32'(in_rdy),   32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    single(16'h8000, 8'd100);
    single(16'h0001, 8'd20);
    single(16'h0000, 8'd77);
    single(16'h0010, 8'd3);
    single(16'h0001, 8'd15);
    single(16'h0001, 8'd14);
    single(16'hFFFF, 8'd0);
    single(16'h0100, 8'd255);

    // Back-to-back stream with a downstream stall window.
    lat_chk = 1'b0;
    bm = '{16'h0003, 16'h8001, 16'h0000, 16'h00F0, 16'h0400, 16'h0001, 16'h7FFF, 16'h0020};
    be = '{8'd40, 8'd1, 8'd9, 8'd2, 8'd200, 8'd10, 8'd0, 8'd12};
    run_stream(0);
    check_val("stream_in_rdy_dropped", 32'(saw_stall), 32'd1);
    drain();

    bm = '{}; be = '{};
    for (int i = 0; i < 24; i++) begin
      bm.push_back(16'($urandom) >> $urandom_range(0, 16));
      be.push_back(8'($urandom_range(0, 24)));
    end
    run_stream(1);
    drain();

    // Reset with two beats in flight.
    lat_chk = 1'b1;
    in_vld = 1'b1; in_mant = 16'h0100; in_exp = 8'd50;
    @(posedge clk); #1;
    in_mant = 16'h0002; in_exp = 8'd60;
    @(posedge clk); #2;
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    check_val("midrst_out_vld",  32'(out_vld),  32'd0);
    check_val("midrst_out_mant", 32'(out_mant), 32'd0);
    check_val("midrst_out_exp",  32'(out_exp),  32'd0);
    check_val("midrst_out_zero", 32'(out_zero), 32'd0);
    check_val("midrst_out_uf",   32'(out_uf),   32'd0);
    sb.delete();
    head_seen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check_val("postrst_idle", 32'(out_vld), 32'd0);
    end
    @(posedge clk); #1;
    single(16'h0004, 8'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
